// File: rtl/pwm_pkg.sv
// pwm_pkg: state encoding shared by the dead-time stage and its bench.
package pwm_pkg;
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_DEAD_TO_HI = 3'd1;
    localparam logic [2:0] ST_HI_ON      = 3'd2;
    localparam logic [2:0] ST_DEAD_TO_LO = 3'd3;
    localparam logic [2:0] ST_LO_ON      = 3'd4;
    localparam logic [2:0] ST_FAULT      = 3'd5;
endpackage

// File: rtl/pwm_tiempo_muerto.sv
// pwm_tiempo_muerto: complementary half-bridge drive with dead time, enable,
// latched fault shutdown and a count of high-side turn-ons.
module pwm_tiempo_muerto
    import pwm_pkg::*;
#(
    parameter int DT    = 4,
    parameter int DT_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             enable,
    input  logic             fault_in,
    input  logic             fault_clear,
    output logic             out_hi,
    output logic             out_lo,
    output logic             fault_latched,
    output logic [2:0]       estado,
    output logic [CNT_W-1:0] sw_count
);
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT - 1);

    if (DT < 1 || DT > (2**DT_W) - 1) begin : g_dt_check
        $error("pwm_tiempo_muerto: DT out of range 1..2**DT_W-1");
    end

    logic             r_p_q;
    logic [2:0]       r_state;
    logic [DT_W-1:0]  r_cnt;
    logic             r_from_on;
    logic [CNT_W-1:0] r_sw;
    logic [2:0]       w_next;
    logic [DT_W-1:0]  w_cnt_next;
    logic             w_from_on_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_q     <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_from_on <= 1'b0;
            r_sw      <= '0;
        end else begin
            r_p_q     <= pwm_in;
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_from_on <= w_from_on_next;
            if (w_next == ST_HI_ON && r_state != ST_HI_ON)
                r_sw <= r_sw + 1'b1;
        end
    end

    // r_from_on marks a dead interval that left a conducting leg, which may be
    // abandoned early because the opposite leg never turned on.
    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_from_on_next = r_from_on;
        if (fault_in)
            w_next = ST_FAULT;
        else if (r_state == ST_FAULT)
            w_next = fault_clear ? ST_IDLE : ST_FAULT;
        else if (!enable)
            w_next = ST_IDLE;
        else begin
            case (r_state)
                ST_IDLE: begin
                    w_next         = r_p_q ? ST_DEAD_TO_HI : ST_DEAD_TO_LO;
                    w_cnt_next     = DT_LOAD;
                    w_from_on_next = 1'b0;
                end
                ST_DEAD_TO_HI: begin
                    if (!r_p_q && r_from_on)
                        w_next = ST_LO_ON;
                    else if (r_cnt != '0)
                        w_cnt_next = r_cnt - 1'b1;
                    else if (r_p_q)
                        w_next = ST_HI_ON;
                    else begin
                        w_next         = ST_DEAD_TO_LO;
                        w_cnt_next     = DT_LOAD;
                        w_from_on_next = 1'b0;
                    end
                end
                ST_DEAD_TO_LO: begin
                    if (r_p_q && r_from_on)
                        w_next = ST_HI_ON;
                    else if (r_cnt != '0)
                        w_cnt_next = r_cnt - 1'b1;
                    else if (!r_p_q)
                        w_next = ST_LO_ON;
                    else begin
                        w_next         = ST_DEAD_TO_HI;
                        w_cnt_next     = DT_LOAD;
                        w_from_on_next = 1'b0;
                    end
                end
                ST_HI_ON: begin
                    if (!r_p_q) begin
                        w_next         = ST_DEAD_TO_LO;
                        w_cnt_next     = DT_LOAD;
                        w_from_on_next = 1'b1;
                    end
                end
                ST_LO_ON: begin
                    if (r_p_q) begin
                        w_next         = ST_DEAD_TO_HI;
                        w_cnt_next     = DT_LOAD;
                        w_from_on_next = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_hi        = (r_state == ST_HI_ON);
        out_lo        = (r_state == ST_LO_ON);
        fault_latched = (r_state == ST_FAULT);
        estado        = r_state;
        sw_count      = r_sw;
    end
endmodule

// File: tb/tb_pwm_tiempo_muerto.sv
// tb_pwm_tiempo_muerto: scoreboard bench; a leg/target reference model predicts
// every cycle's outputs and a monitor compares them against the DUT.
module tb_pwm_tiempo_muerto;
    import pwm_pkg::*;

    localparam int DT = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       hi;
        logic       lo;
        logic       flt;
        logic [2:0] st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk, reset, pwm_in, enable, fault_in, fault_clear;
    logic out_hi, out_lo, fault_latched;
    logic [2:0] estado;
    logic [CNT_W-1:0] sw_count;

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];

    pwm_tiempo_muerto #(.DT(DT), .DT_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable),
        .fault_in(fault_in), .fault_clear(fault_clear),
        .out_hi(out_hi), .out_lo(out_lo), .fault_latched(fault_latched),
        .estado(estado), .sw_count(sw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: which leg conducts (0 none, 1 lo, 2 hi), which leg a dead interval
    // heads for, which leg it left, and how many dead cycles remain.
    initial begin
        int leg, tgt, prev, left, cnt, want;
        bit flt, p;
        exp_t e;
        leg = 0; tgt = 0; prev = 0; left = 0; cnt = 0; flt = 0; p = 0;
        forever begin
            @(posedge clk);
            want = p ? 2 : 1;
            if (reset) begin
                leg = 0; tgt = 0; prev = 0; left = 0; cnt = 0; flt = 0;
            end else if (fault_in) begin
                flt = 1; leg = 0; tgt = 0;
            end else if (flt) begin
                if (fault_clear) flt = 0;
            end else if (!enable) begin
                leg = 0; tgt = 0;
            end else if (tgt == 0 && leg == 0) begin
                tgt = want; left = DT; prev = 0;
            end else if (tgt == 0) begin
                if (want != leg) begin
                    tgt = want; prev = leg; leg = 0; left = DT;
                end
            end else if (want == prev) begin
                leg = prev; tgt = 0;
                if (leg == 2) cnt++;
            end else begin
                left--;
                if (left == 0) begin
                    if (want == tgt) begin
                        leg = tgt; tgt = 0;
                        if (leg == 2) cnt++;
                    end else begin
                        tgt = want; left = DT; prev = 0;
                    end
                end
            end
            p = reset ? 1'b0 : pwm_in;
            e.hi  = (leg == 2) && !flt;
            e.lo  = (leg == 1) && !flt;
            e.flt = flt;
            e.st  = flt ? ST_FAULT : leg == 2 ? ST_HI_ON : leg == 1 ? ST_LO_ON :
                    tgt == 2 ? ST_DEAD_TO_HI : tgt == 1 ? ST_DEAD_TO_LO : ST_IDLE;
            e.cnt = CNT_W'(cnt % (2**CNT_W));
            sb_q.push_back(e);
        end
    end

    initial begin
        int cyc, lo_fall, hi_fall;
        logic prev_hi, prev_lo;
        exp_t e, a;
        cyc = 0; lo_fall = -100; hi_fall = -100; prev_hi = 0; prev_lo = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            a = '{out_hi, out_lo, fault_latched, estado, sw_count};
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty cycle=%0d got=%h expected a queued entry", cyc, a);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got hi=%b lo=%b flt=%b st=%0d cnt=%0d want hi=%b lo=%b flt=%b st=%0d cnt=%0d",
                             cyc, a.hi, a.lo, a.flt, a.st, a.cnt, e.hi, e.lo, e.flt, e.st, e.cnt);
                end
            end
            total++;
            if (out_hi && out_lo) begin
                bad++;
                $display("FAIL overlap cycle=%0d got hi=1 lo=1 want not both", cyc);
            end
            if (prev_lo && !out_lo) lo_fall = cyc;
            if (prev_hi && !out_hi) hi_fall = cyc;
            if (!prev_hi && out_hi) begin
                total++;
                if (cyc - lo_fall < DT) begin
                    bad++;
                    $display("FAIL gap_lo_hi cycle=%0d got=%0d want>=%0d", cyc, cyc - lo_fall, DT);
                end
            end
            if (!prev_lo && out_lo) begin
                total++;
                if (cyc - hi_fall < DT) begin
                    bad++;
                    $display("FAIL gap_hi_lo cycle=%0d got=%0d want>=%0d", cyc, cyc - hi_fall, DT);
                end
            end
            prev_hi = out_hi;
            prev_lo = out_lo;
        end
    end

    task automatic drive(input logic p, input logic en, input logic fi, input logic fc, input logic r);
        @(negedge clk);
        pwm_in = p; enable = en; fault_in = fi; fault_clear = fc; reset = r;
    endtask

    task automatic hold(input logic p, input int n);
        for (int i = 0; i < n; i++) drive(p, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; pwm_in = 1'b0; enable = 1'b1; fault_in = 1'b0; fault_clear = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'(i % 2), 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 20);
        hold(1'b1, 20);
        hold(1'b0, 20);
        hold(1'b1, 3);
        hold(1'b0, 15);
        hold(1'b1, 20);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 10);
        hold(1'b0, 15);
        hold(1'b1, 2);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 12);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 10);
        for (int i = 0; i < 17; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        @(posedge clk);
        #2;
        total++;
        if (sw_count !== CNT_W'(1)) begin
            bad++;
            $display("FAIL wrap got=%0d want=1", sw_count);
        end
        for (int s = 0; s < 300; s++) begin
            logic p, en;
            int len;
            p = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 19) != 0);
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++)
                drive(p, en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 199) == 0));
        end
        hold(1'b0, 5);
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
